// File: rtl/som_pic_writeback_pkg.sv
// rtl/som_pic_writeback_pkg.sv - shared constants, FSM encodings and VEP index helper
package som_pic_writeback_pkg;

  localparam int VEP_WEIGHT_W = 24;
  localparam int GRID_DIM     = 8;
  localparam int N_VEP        = 64;
  localparam int PIC_ADDR_W   = 18;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_SETUP,
    W_STROBE
  } wstate_e;

  // Row-major VEP number of the winner on the GRID_DIM x GRID_DIM array
  function automatic logic [5:0] vep_index(input logic [2:0] x, input logic [2:0] y);
    return 6'(int'(y) * GRID_DIM + int'(x));
  endfunction

endpackage

// File: rtl/som_pic_writeback_if.sv
// rtl/som_pic_writeback_if.sv - pixel/winner input handshake and RAM_PIC write bus
interface som_pic_writeback_if #(
  parameter int ADDR_W = 18,
  parameter int N_VEP  = 64
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_W-1:0]     in_addr;
  logic [2:0]            winner_x;
  logic [2:0]            winner_y;
  logic [24*N_VEP-1:0]   weight_bus;
  logic                  RAM_PIC_OE;
  logic                  RAM_PIC_WE;
  logic [ADDR_W-1:0]     RAM_PIC_A;
  logic [23:0]           RAM_PIC_D;

  modport master (
    output in_valid, in_addr, winner_x, winner_y, weight_bus,
    input  in_ready, RAM_PIC_OE, RAM_PIC_WE, RAM_PIC_A, RAM_PIC_D
  );

  modport slave (
    input  in_valid, in_addr, winner_x, winner_y, weight_bus,
    output in_ready, RAM_PIC_OE, RAM_PIC_WE, RAM_PIC_A, RAM_PIC_D
  );
endinterface

// File: rtl/som_wb_fifo.sv
// rtl/som_wb_fifo.sv - synchronous FIFO with wrap-bit pointers, no push/pop bypass
module som_wb_fifo #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wr_ptr_q;
  logic [PW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign rd_data = mem_q[rd_ptr_q[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en && !full)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en && !empty) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full) mem_q[wr_ptr_q[PW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/som_pic_writeback.sv
// rtl/som_pic_writeback.sv - captures winner VEP weights per pixel and writes them to RAM_PIC
module som_pic_writeback #(
  parameter int ADDR_W     = som_pic_writeback_pkg::PIC_ADDR_W,
  parameter int NUM_PIX    = 65536,
  parameter int N_VEP      = som_pic_writeback_pkg::N_VEP,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  som_pic_writeback_if.slave bus
);
  import som_pic_writeback_pkg::*;

  localparam int CNT_W = $clog2(NUM_PIX) + 1;
  localparam int EW    = ADDR_W + VEP_WEIGHT_W;
  localparam int WB_W  = VEP_WEIGHT_W * N_VEP;
  localparam logic [CNT_W-1:0] NUM_PIX_C = CNT_W'(NUM_PIX);

  state_e                  state_q;
  wstate_e                 wstate_q;
  logic                    busy_q, done_q, we_q;
  logic [ADDR_W-1:0]       a_q;
  logic [VEP_WEIGHT_W-1:0] d_q;
  logic [CNT_W-1:0]        acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]        wr_cnt_q, wr_cnt_d;

  logic                    in_ready, push, pop, clr, wr_last;
  logic                    fifo_full, fifo_empty;
  logic [EW-1:0]           fifo_wdata, fifo_rdata;
  logic [WB_W-1:0]         wb;
  logic [VEP_WEIGHT_W-1:0] sel_w;

  assign wb         = bus.weight_bus;
  assign sel_w      = wb[VEP_WEIGHT_W*int'(vep_index(bus.winner_x, bus.winner_y)) +: VEP_WEIGHT_W];
  assign fifo_wdata = {bus.in_addr, sel_w};

  assign in_ready  = (state_q == ST_RUN) && !fifo_full && (acc_cnt_q < NUM_PIX_C);
  assign push      = bus.in_valid && in_ready;
  assign clr       = start && (state_q != ST_RUN);
  assign acc_cnt_d = push ? acc_cnt_q + CNT_W'(1) : acc_cnt_q;
  assign wr_cnt_d  = wr_cnt_q + CNT_W'(1);
  // The strobe that brings wr_cnt to NUM_PIX ends the frame on the same edge
  assign wr_last   = (wstate_q == W_STROBE) && (wr_cnt_d == NUM_PIX_C);
  assign pop       = (state_q == ST_RUN) && !fifo_empty &&
                     ((wstate_q == W_IDLE) || ((wstate_q == W_STROBE) && !wr_last));

  som_wb_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .wr_en   (push),
    .wr_data (fifo_wdata),
    .rd_en   (pop),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      acc_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q   <= ST_RUN;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            acc_cnt_q <= '0;
          end
        end
        ST_RUN: begin
          acc_cnt_q <= acc_cnt_d;
          if (wr_last) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate_q <= W_IDLE;
      we_q     <= 1'b0;
      a_q      <= '0;
      d_q      <= '0;
      wr_cnt_q <= '0;
    end else if (state_q != ST_RUN) begin
      wstate_q <= W_IDLE;
      we_q     <= 1'b0;
      if (start) wr_cnt_q <= '0;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          if (pop) begin
            {a_q, d_q} <= fifo_rdata;
            wstate_q   <= W_SETUP;
          end
        end
        W_SETUP: begin
          we_q     <= 1'b1;
          wstate_q <= W_STROBE;
        end
        W_STROBE: begin
          we_q     <= 1'b0;
          wr_cnt_q <= wr_cnt_d;
          if (pop) begin
            {a_q, d_q} <= fifo_rdata;
            wstate_q   <= W_SETUP;
          end else begin
            wstate_q <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.RAM_PIC_OE = 1'b0;
  assign bus.RAM_PIC_WE = we_q;
  assign bus.RAM_PIC_A  = a_q;
  assign bus.RAM_PIC_D  = d_q;
  assign busy           = busy_q;
  assign done           = done_q;
endmodule

// File: tb/tb_som_pic_writeback.sv
// tb/tb_som_pic_writeback.sv - directed self-checking bench for som_pic_writeback
module tb_som_pic_writeback;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start4 = 1'b0, start16 = 1'b0;
  logic busy4, done4, busy16, done16;

  som_pic_writeback_if #(.ADDR_W(18), .N_VEP(64)) if4 ();
  som_pic_writeback_if #(.ADDR_W(18), .N_VEP(64)) if16 ();

  som_pic_writeback #(.ADDR_W(18), .NUM_PIX(4), .N_VEP(64), .FIFO_DEPTH(4)) u_dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .busy  (busy4),
    .done  (done4),
    .bus   (if4.slave)
  );

  som_pic_writeback #(.ADDR_W(18), .NUM_PIX(16), .N_VEP(64), .FIFO_DEPTH(4)) u_dut16 (
    .clk   (clk),
    .rst   (rst),
    .start (start16),
    .busy  (busy16),
    .done  (done16),
    .bus   (if16.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [17:0] px_addr [6];
  logic [2:0]  px_x [6];
  logic [2:0]  px_y [6];
  logic [23:0] exp_d [4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [24*64-1:0] ramp_bus();
    logic [24*64-1:0] b;
    for (int k = 0; k < 64; k++) b[24*k +: 24] = {3{8'(k)}};
    return b;
  endfunction

  // One NUM_PIX=4 frame: cycle 0 is the first cycle in RUN
  task automatic frame4(input string name, input int nv, input bit cap, input bit restart_mid);
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      check($sformatf("%s_busy_c%0d", name, c), busy4, c < 10);
      check($sformatf("%s_done_c%0d", name, c), done4, c >= 10);
      if (c < nv) check($sformatf("%s_ready_c%0d", name, c), if4.in_ready, c < 4);
      check($sformatf("%s_we_c%0d", name, c), if4.RAM_PIC_WE, (c == 3) || (c == 5) || (c == 7) || (c == 9));
      if ((c == 3) || (c == 5) || (c == 7) || (c == 9)) begin
        check($sformatf("%s_a_c%0d", name, c), if4.RAM_PIC_A, px_addr[(c-3)/2]);
        check($sformatf("%s_d_c%0d", name, c), if4.RAM_PIC_D, exp_d[(c-3)/2]);
      end
      if (c < nv) begin
        if4.in_valid = 1'b1;
        if4.in_addr  = px_addr[c];
        if4.winner_x = px_x[c];
        if4.winner_y = px_y[c];
      end else begin
        if4.in_valid = 1'b0;
        if4.in_addr  = 'x;
        if4.winner_x = 'x;
        if4.winner_y = 'x;
      end
      start4 = restart_mid && (c == 1);
      if (cap && (c == 1)) if4.weight_bus[24*2 +: 24] = 24'h555555;
    end
    start4 = 1'b0;
  endtask

  task automatic load_basic(input logic [17:0] base);
    for (int i = 0; i < 4; i++) px_addr[i] = base + 18'(i);
    px_x[0] = 3'd1; px_y[0] = 3'd0;
    px_x[1] = 3'd7; px_y[1] = 3'd7;
    px_x[2] = 3'd0; px_y[2] = 3'd1;
    px_x[3] = 3'd3; px_y[3] = 3'd2;
    exp_d[0] = 24'h010101; exp_d[1] = 24'h3F3F3F;
    exp_d[2] = 24'h080808; exp_d[3] = 24'h131313;
  endtask

  initial begin
    int sent;
    int wn;
    int c;

    if4.in_valid = 1'b0;  if16.in_valid = 1'b0;
    if4.in_addr  = '0;    if16.in_addr  = '0;
    if4.winner_x = '0;    if16.winner_x = '0;
    if4.winner_y = '0;    if16.winner_y = '0;
    if4.weight_bus  = ramp_bus();
    if16.weight_bus = ramp_bus();

    #12;
    check("rst_ready4", if4.in_ready, 1'b0);
    check("rst_oe4", if4.RAM_PIC_OE, 1'b0);
    check("rst_we4", if4.RAM_PIC_WE, 1'b0);
    check("rst_a4", if4.RAM_PIC_A, 18'h0);
    check("rst_d4", if4.RAM_PIC_D, 24'h0);
    check("rst_busy4", busy4, 1'b0);
    check("rst_done4", done4, 1'b0);
    check("rst_ready16", if16.in_ready, 1'b0);
    check("rst_busy16", busy16, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Backpressure on the NUM_PIX=16 instance with in_valid held high
    @(negedge clk);
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    sent = 0;
    wn = 0;
    c = 0;
    while (!done16 && c < 300) begin
      if (c > 0) @(negedge clk);
      if (done16) break;
      if (c == 6) check("bp_ready_c6", if16.in_ready, 1'b1);
      if (c == 7) check("bp_ready_c7", if16.in_ready, 1'b0);
      if (c == 8) check("bp_ready_c8", if16.in_ready, 1'b1);
      if (if16.RAM_PIC_WE) begin
        check($sformatf("bp_a_w%0d", wn), if16.RAM_PIC_A, 64'(wn));
        check($sformatf("bp_d_w%0d", wn), if16.RAM_PIC_D, {3{8'(wn)}});
        wn++;
      end
      if16.in_valid = 1'b1;
      if16.in_addr  = 18'(sent);
      if16.winner_x = 3'(sent % 8);
      if16.winner_y = 3'(sent / 8);
      if (if16.in_ready) sent++;
      c++;
    end
    check("bp_no_timeout", c < 300, 1'b1);
    check("bp_done", done16, 1'b1);
    check("bp_writes", 64'(wn), 64'd16);
    check("bp_accepted", 64'(sent), 64'd16);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp_post_we_%0d", i), if16.RAM_PIC_WE, 1'b0);
      check($sformatf("bp_post_ready_%0d", i), if16.in_ready, 1'b0);
    end
    if16.in_valid = 1'b0;

    // Basic four-pixel frame
    load_basic(18'd0);
    frame4("basic", 4, 1'b0, 1'b0);

    // Restart from DONE, weight captured at acceptance, start during RUN ignored
    for (int i = 0; i < 4; i++) begin
      px_addr[i] = 18'd10 + 18'(i);
      px_x[i] = 3'd2;
      px_y[i] = 3'd0;
    end
    exp_d[0] = 24'hAAAAAA;
    exp_d[1] = 24'h555555; exp_d[2] = 24'h555555; exp_d[3] = 24'h555555;
    if4.weight_bus[24*2 +: 24] = 24'hAAAAAA;
    frame4("cap", 4, 1'b1, 1'b1);

    // Six valid pixels offered, only four accepted
    if4.weight_bus = ramp_bus();
    for (int i = 0; i < 6; i++) begin
      px_addr[i] = 18'd20 + 18'(i);
      px_x[i] = 3'd4;
      px_y[i] = 3'd4;
    end
    for (int i = 0; i < 4; i++) exp_d[i] = 24'h242424;
    frame4("ovf", 6, 1'b0, 1'b0);

    // Asynchronous reset while the first write is strobing
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    if4.in_valid = 1'b1;
    if4.in_addr  = 18'd30;
    if4.winner_x = 3'd0;
    if4.winner_y = 3'd0;
    @(negedge clk);
    if4.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("arst_we_before", if4.RAM_PIC_WE, 1'b1);
    check("arst_a_before", if4.RAM_PIC_A, 18'd30);
    check("arst_ready_before", if4.in_ready, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("arst_we", if4.RAM_PIC_WE, 1'b0);
    check("arst_busy", busy4, 1'b0);
    check("arst_ready", if4.in_ready, 1'b0);
    check("arst_done", done4, 1'b0);
    check("arst_a", if4.RAM_PIC_A, 18'h0);
    check("arst_d", if4.RAM_PIC_D, 24'h0);
    @(negedge clk);
    rst = 1'b0;

    // Clean frame after the reset
    load_basic(18'd40);
    frame4("post_rst", 4, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/som_pic_writeback.md
Name: som_pic_writeback

Overview:
- Reconstruction stage directly downstream of the SOM core (VEP array plus winner search).
- Per reconstructed pixel, receives the pixel address and winner VEP coordinates, captures that VEP's 24-bit weight, and buffers {address, weight} in a small FIFO.
- Writes each entry to RAM_PIC with a 2-cycle write protocol; asserts done after NUM_PIX writes.

Parameters:
- ADDR_W, 18, RAM_PIC address width
- NUM_PIX, 65536, pixels per frame (writes before done)
- N_VEP, 64, VEP count (8x8 grid); weight_bus width = 24*N_VEP
- FIFO_DEPTH, 4, entries; power of two, >=2

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins a frame
- in_valid  in  1  pixel address/winner valid
- in_ready  out  1  block accepts this cycle
- in_addr  in  ADDR_W  destination pixel address
- winner_x  in  3  winner column
- winner_y  in  3  winner row
- weight_bus  in  24*N_VEP  all VEP weights; VEP k at [24k+:24], k = y*8+x
- RAM_PIC_OE  out  1  always 0
- RAM_PIC_WE  out  1  write strobe
- RAM_PIC_A  out  ADDR_W  write address
- RAM_PIC_D  out  24  write data
- busy  out  1  frame in progress
- done  out  1  frame complete, held

Behaviour:
- Reset values: in_ready=0, RAM_PIC_OE=0, RAM_PIC_WE=0, RAM_PIC_A=0, RAM_PIC_D=0, busy=0, done=0. FIFO is empty. Counters acc_cnt and wr_cnt are 0. FSM is IDLE.
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN. Clears acc_cnt, wr_cnt, FIFO and done.
  - RUN --(wr_cnt==NUM_PIX after a write completes)--> DONE.
  - DONE --start--> RUN, with the same clears.
  - start in RUN is ignored.
- busy = (state==RUN). done = (state==DONE), registered.
- Accept: in_ready = RUN && !fifo_full && acc_cnt<NUM_PIX. Push on in_valid&&in_ready.
- Weight select on push, same cycle: entry.data = weight_bus[24*(winner_y*8+winner_x)+:24], entry.addr = in_addr. Data is captured at acceptance; later weight_bus changes do not affect it.
- Push/pop use no same-cycle bypass. A full FIFO deasserts in_ready even if a pop occurs that cycle.
- Write engine (sub-FSM W_IDLE, W_SETUP, W_STROBE) runs in RUN only.
  - W_IDLE with FIFO non-empty: pop head into output regs A/D, go to W_SETUP.
  - W_SETUP: WE=0, A/D stable, go to W_STROBE.
  - W_STROBE: WE=1, A/D unchanged, wr_cnt++.
  - After W_STROBE: if FIFO non-empty, pop directly into W_SETUP; otherwise go to W_IDLE.
  - Peak throughput is 1 write per 2 cycles.
- A/D hold their last values between writes. WE is high only in W_STROBE.
- Latency: first accepted pixel at cycle t gives WE=1 at cycle t+3.
- wr_cnt reaching NUM_PIX moves the FSM to DONE on the next edge. The final write's WE pulse completes normally.
- acc_cnt saturates at NUM_PIX. Inputs beyond that are not accepted.
- Counter widths are clog2(NUM_PIX)+1 bits, so 65536 is representable without wrap.
- FIFO pointers are clog2(FIFO_DEPTH)+1 bits with wrap bit. full = MSBs differ and lower bits equal. empty = pointers equal.
- Async rst mid-frame: all outputs return to reset values immediately (WE drops asynchronously). FIFO contents are discarded.
- winner_x/y/in_addr may be X when in_valid=0 and must not propagate.

Decomposition:
- Shared package: VEP_WEIGHT_W=24, GRID_DIM=8, N_VEP=64, PIC_ADDR_W=18, FSM state encodings.
- One sub-module: som_wb_fifo, a synchronous FIFO (width ADDR_W+24, depth FIFO_DEPTH) with full/empty.

Test Plan:
- Basic write: NUM_PIX=4, start, then one valid per cycle with addr 0..3, winner (x,y)=(1,0),(7,7),(0,1),(3,2), and weight_bus VEP k = {8'hk,8'hk,8'hk} → WE pulses at cycles 3,5,7,9 with D=010101,3F3F3F,080808,131313. done=1 one cycle after the last WE.
- Backpressure: in_valid held high, NUM_PIX=16 → in_ready drops after 4 buffered plus 1 in flight. Exactly 16 WE pulses with no duplicate or missing address.
- Capture timing: change weight_bus of the winner VEP from 0xAAAAAA to 0x555555 one cycle after acceptance → written D=0xAAAAAA.
- Overflow guard: NUM_PIX=4, drive 6 valid pixels → only 4 accepted (in_ready=0 after the 4th). 4 WE pulses, done=1.
- Reset mid-frame: assert rst asynchronously during W_STROBE → WE=0, busy=0, in_ready=0 before the next edge. A new start runs a clean frame from wr_cnt=0.
- Restart from DONE: start pulse → done=0, busy=1 the next cycle. A start issued during RUN changes nothing.
